// File: rtl/loop_addr_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : loop_addr_gen_if
//  Purpose  : Address stream from the two-level loop generator to its
//             consumer. The address, loop indices and end-of-run flag travel
//             with a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
interface loop_addr_gen_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 8
);
    logic                   addr_valid;
    logic                   addr_ready;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [COUNT_WIDTH-1:0] inner_cnt;
    logic [COUNT_WIDTH-1:0] outer_cnt;
    logic                   last;

    // Generator side: produces the stream and observes ready.
    modport master (
        output addr_valid,
        output addr,
        output inner_cnt,
        output outer_cnt,
        output last,
        input  addr_ready
    );

    // Consumer side: observes the stream and drives ready.
    modport slave (
        input  addr_valid,
        input  addr,
        input  inner_cnt,
        input  outer_cnt,
        input  last,
        output addr_ready
    );
endinterface
`default_nettype wire

// File: rtl/loop_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : loop_addr_gen
//  Purpose  : Two-level nested-loop address generator. One address is issued
//             per handshake; the inner loop steps by the inner stride and each
//             new outer iteration restarts from the previous row base plus the
//             outer stride. Only adders are used, and wrap is modulo
//             2^ADDR_WIDTH.
//  Revision : 1.0  initial release
// ============================================================================
module loop_addr_gen #(
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   clear,
    input  wire logic                   start,
    input  wire logic [ADDR_WIDTH-1:0]  base_addr,
    input  wire logic [ADDR_WIDTH-1:0]  inner_stride,
    input  wire logic [ADDR_WIDTH-1:0]  outer_stride,
    input  wire logic [COUNT_WIDTH-1:0] inner_max,
    input  wire logic [COUNT_WIDTH-1:0] outer_max,
    output logic                        busy,
    output logic                        done,
    loop_addr_gen_if.master             addr_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    // Configuration captured when a run is accepted
    logic [ADDR_WIDTH-1:0]  r_inner_stride;
    logic [ADDR_WIDTH-1:0]  r_outer_stride;
    logic [COUNT_WIDTH-1:0] r_inner_max;
    logic [COUNT_WIDTH-1:0] r_outer_max;

    // Loop position
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH-1:0]  r_row_base;
    logic [COUNT_WIDTH-1:0] r_inner_cnt;
    logic [COUNT_WIDTH-1:0] r_outer_cnt;

    logic                   w_accept;
    logic                   w_handshake;
    logic                   w_inner_end;
    logic                   w_outer_end;
    logic                   w_last;
    logic [ADDR_WIDTH-1:0]  w_next_row;

    assign w_inner_end = (r_inner_cnt == r_inner_max);
    assign w_outer_end = (r_outer_cnt == r_outer_max);
    assign w_last      = w_inner_end & w_outer_end & (r_state == RUN);
    assign w_handshake = (r_state == RUN) & addr_if.addr_ready;
    assign w_next_row  = r_row_base + r_outer_stride;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived outputs; clear overrides all
    always_comb begin
        w_state_next       = r_state;
        w_accept           = 1'b0;
        addr_if.addr_valid = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !clear) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                addr_if.addr_valid = 1'b1;
                busy               = 1'b1;
                if (w_handshake && w_last) begin
                    w_state_next = FIN;
                end
            end
            FIN: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (clear) begin
            w_state_next = IDLE;
        end
    end

    // Configuration capture and loop advance on each accepted address
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inner_stride <= '0;
            r_outer_stride <= '0;
            r_inner_max    <= '0;
            r_outer_max    <= '0;
            r_addr         <= '0;
            r_row_base     <= '0;
            r_inner_cnt    <= '0;
            r_outer_cnt    <= '0;
        end else if (clear) begin
            r_addr         <= '0;
            r_row_base     <= '0;
            r_inner_cnt    <= '0;
            r_outer_cnt    <= '0;
        end else if (w_accept) begin
            r_inner_stride <= inner_stride;
            r_outer_stride <= outer_stride;
            r_inner_max    <= inner_max;
            r_outer_max    <= outer_max;
            r_addr         <= base_addr;
            r_row_base     <= base_addr;
            r_inner_cnt    <= '0;
            r_outer_cnt    <= '0;
        end else if (w_handshake && !w_last) begin
            if (!w_inner_end) begin
                r_inner_cnt <= r_inner_cnt + 1'b1;
                r_addr      <= r_addr + r_inner_stride;
            end else begin
                // Row complete: start the next row from the stored row base
                r_inner_cnt <= '0;
                r_outer_cnt <= r_outer_cnt + 1'b1;
                r_row_base  <= w_next_row;
                r_addr      <= w_next_row;
            end
        end
    end

    assign addr_if.addr      = r_addr;
    assign addr_if.inner_cnt = r_inner_cnt;
    assign addr_if.outer_cnt = r_outer_cnt;
    assign addr_if.last      = w_last;

endmodule
`default_nettype wire

// File: tb/tb_loop_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_loop_addr_gen
//  Purpose  : Directed self-checking bench for loop_addr_gen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_loop_addr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] inner_stride;
    logic [15:0] outer_stride;
    logic [7:0]  inner_max;
    logic [7:0]  outer_max;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    loop_addr_gen_if #(.ADDR_WIDTH(16), .COUNT_WIDTH(8)) bus ();

    loop_addr_gen #(.ADDR_WIDTH(16), .COUNT_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .start        (start),
        .base_addr    (base_addr),
        .inner_stride (inner_stride),
        .outer_stride (outer_stride),
        .inner_max    (inner_max),
        .outer_max    (outer_max),
        .busy         (busy),
        .done         (done),
        .addr_if      (bus.master)
    );

    always #5 clk = ~clk;

    // Hand-computed sequence for base 0x100, is 4, os 0x40, im 2, om 1
    logic [15:0] exp_addr [6] = '{16'h0100, 16'h0104, 16'h0108,
                                  16'h0140, 16'h0144, 16'h0148};
    logic [7:0]  exp_in   [6] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
    logic [7:0]  exp_out  [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};

    task automatic set_cfg(input logic [15:0] b, input logic [15:0] is,
                           input logic [15:0] os, input logic [7:0] im,
                           input logic [7:0] om);
        base_addr    = b;
        inner_stride = is;
        outer_stride = os;
        inner_max    = im;
        outer_max    = om;
    endtask

    task automatic test_reset;
        reset = 1'b1; clear = 1'b0; start = 1'b0; bus.addr_ready = 1'b0;
        set_cfg(16'h0, 16'h0, 16'h0, 8'h0, 8'h0);
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.addr_valid, bus.last, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.addr_valid, bus.last, busy, done});
        end
        n_checks++;
        if ({bus.addr, bus.inner_cnt, bus.outer_cnt} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr_cnt: got %h expected 0",
                     {bus.addr, bus.inner_cnt, bus.outer_cnt});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        set_cfg(16'h0100, 16'h0004, 16'h0040, 8'd2, 8'd1);
        bus.addr_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (bus.addr_valid !== 1'b1 || bus.addr !== exp_addr[i] ||
                bus.inner_cnt !== exp_in[i] || bus.outer_cnt !== exp_out[i] ||
                bus.last !== (i == 5) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got v=%b a=%h i=%0d o=%0d l=%b b=%b expected v=1 a=%h i=%0d o=%0d l=%b b=1",
                         i, bus.addr_valid, bus.addr, bus.inner_cnt, bus.outer_cnt,
                         bus.last, busy, exp_addr[i], exp_in[i], exp_out[i], (i == 5));
            end
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1 || bus.addr_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got d=%b v=%b b=%b expected d=1 v=0 b=0",
                     done, bus.addr_valid, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || bus.addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got d=%b v=%b expected d=0 v=0", done, bus.addr_valid);
        end
    endtask

    task automatic test_backpressure;
        int idx;
        int cyc;
        logic phase;
        set_cfg(16'h0100, 16'h0004, 16'h0040, 8'd2, 8'd1);
        bus.addr_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        phase = 1'b1;
        cyc = 0;
        while (idx < 6 && cyc < 30) begin
            n_checks++;
            if (bus.addr_valid !== 1'b1 || bus.addr !== exp_addr[idx] ||
                bus.last !== (idx == 5)) begin
                n_fail++;
                $display("FAIL bp_cycle%0d: got v=%b a=%h l=%b expected v=1 a=%h l=%b",
                         cyc, bus.addr_valid, bus.addr, bus.last, exp_addr[idx], (idx == 5));
            end
            bus.addr_ready = phase;
            @(negedge clk);
            if (phase) idx++;
            phase = ~phase;
            cyc++;
        end
        bus.addr_ready = 1'b1;
        n_checks++;
        if (idx != 6 || cyc != 11) begin
            n_fail++;
            $display("FAIL bp_count: got %0d handshakes in %0d cycles expected 6 in 11", idx, cyc);
        end
        n_checks++;
        if (done !== 1'b1 || bus.addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: got d=%b v=%b expected d=1 v=0", done, bus.addr_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_single;
        set_cfg(16'h0020, 16'h0004, 16'h0040, 8'd0, 8'd0);
        bus.addr_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (bus.addr_valid !== 1'b1 || bus.addr !== 16'h0020 || bus.last !== 1'b1) begin
            n_fail++;
            $display("FAIL single_addr: got v=%b a=%h l=%b expected v=1 a=0020 l=1",
                     bus.addr_valid, bus.addr, bus.last);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || bus.addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got d=%b v=%b expected d=1 v=0", done, bus.addr_valid);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_pulse: got d=%b expected 0", done);
        end
    endtask

    task automatic test_wrap;
        set_cfg(16'hFFFC, 16'h0004, 16'h0010, 8'd1, 8'd0);
        bus.addr_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (bus.addr !== 16'hFFFC || bus.last !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_first: got a=%h l=%b expected a=fffc l=0", bus.addr, bus.last);
        end
        @(negedge clk);
        n_checks++;
        if (bus.addr !== 16'h0000 || bus.last !== 1'b1 || bus.inner_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL wrap_second: got a=%h l=%b i=%0d expected a=0000 l=1 i=1",
                     bus.addr, bus.last, bus.inner_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_done: got %b expected 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_clear;
        set_cfg(16'h0100, 16'h0004, 16'h0040, 8'd2, 8'd1);
        bus.addr_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.addr !== 16'h0108) begin
            n_fail++;
            $display("FAIL clear_pre: got a=%h expected 0108", bus.addr);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (bus.addr_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
            bus.inner_cnt !== 8'd0 || bus.outer_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_idle: got v=%b d=%b b=%b i=%0d o=%0d expected all 0",
                     bus.addr_valid, done, busy, bus.inner_cnt, bus.outer_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || bus.addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_no_done: got d=%b v=%b expected 0 0", done, bus.addr_valid);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (bus.addr_valid !== 1'b1 || bus.addr !== 16'h0100 || bus.inner_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_restart: got v=%b a=%h i=%0d expected v=1 a=0100 i=0",
                     bus.addr_valid, bus.addr, bus.inner_cnt);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midrun;
        set_cfg(16'h0100, 16'h0004, 16'h0040, 8'd2, 8'd1);
        bus.addr_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.addr_valid, bus.last, busy, done} !== 4'b0000 ||
            {bus.addr, bus.inner_cnt, bus.outer_cnt} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_midrun: got flags=%b a=%h i=%0d o=%0d expected all 0",
                     {bus.addr_valid, bus.last, busy, done}, bus.addr, bus.inner_cnt, bus.outer_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (bus.addr_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_start: got v=%b b=%b expected 0 0", bus.addr_valid, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (bus.addr_valid !== 1'b1 || bus.addr !== 16'h0100) begin
            n_fail++;
            $display("FAIL reset_release_start: got v=%b a=%h expected v=1 a=0100",
                     bus.addr_valid, bus.addr);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        set_cfg(16'h0020, 16'h0004, 16'h0040, 8'd0, 8'd0);
        bus.addr_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        base_addr = 16'h0500;
        @(negedge clk);
        n_checks++;
        if (bus.addr_valid !== 1'b1 || bus.addr !== 16'h0020) begin
            n_fail++;
            $display("FAIL b2b_hold: got v=%b a=%h expected v=1 a=0020", bus.addr_valid, bus.addr);
        end
        bus.addr_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: got %b expected 1", done);
        end
        @(negedge clk);
        n_checks++;
        if (bus.addr_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_fin_start: got v=%b d=%b expected 0 0", bus.addr_valid, done);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (bus.addr_valid !== 1'b1 || bus.addr !== 16'h0500) begin
            n_fail++;
            $display("FAIL b2b_restart: got v=%b a=%h expected v=1 a=0500", bus.addr_valid, bus.addr);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_single();
        test_wrap();
        test_clear();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
